// File: rtl/cpu_types_pkg.sv
// Shared CPU scalar types: register index and machine word.
package cpu_types_pkg;

  localparam int unsigned REG_W  = 5;
  localparam int unsigned WORD_W = 32;

  typedef logic [REG_W-1:0]  regbits_t;
  typedef logic [WORD_W-1:0] word_t;

endpackage

// File: rtl/data_path_muxs_pkg.sv
// Pipeline control state encoding and the per-stage enable/flush control word.
package data_path_muxs_pkg;

  typedef enum logic [1:0] {
    RUN    = 2'd0,
    DRAIN  = 2'd1,
    HALTED = 2'd2
  } pipe_ctrl_state_t;

  typedef struct packed {
    logic pc_en;
    logic en_if_id;
    logic en_id_ex;
    logic en_ex_mem;
    logic en_mem_wb;
    logic fl_if_id;
    logic fl_id_ex;
    logic fl_ex_mem;
    logic fl_mem_wb;
  } ctrl_t;

  // en = {pc, IF/ID, ID/EX, EX/MEM, MEM/WB}, fl = {IF/ID, ID/EX, EX/MEM, MEM/WB}
  function automatic ctrl_t ctrl_word(input logic [4:0] en, input logic [3:0] fl);
    return ctrl_t'({en, fl});
  endfunction

  localparam ctrl_t CTRL_RUN   = ctrl_t'({5'b11111, 4'b0000});
  localparam ctrl_t CTRL_IDLE  = ctrl_t'({5'b00000, 4'b0000});
  localparam ctrl_t CTRL_DMEM  = ctrl_t'({5'b00001, 4'b0001});
  localparam ctrl_t CTRL_HALT  = ctrl_t'({5'b01111, 4'b1110});
  localparam ctrl_t CTRL_LU    = ctrl_t'({5'b00111, 4'b0100});
  localparam ctrl_t CTRL_BR    = ctrl_t'({5'b11111, 4'b1110});
  localparam ctrl_t CTRL_IMISS = ctrl_t'({5'b01111, 4'b1000});

endpackage

// File: rtl/pipeline_ctrl_if.sv
// Hazard/status inputs and stage-control outputs between datapath and pipeline controller.
interface pipeline_ctrl_if;
  import cpu_types_pkg::*;

  logic     ihit;
  logic     dhit;
  logic     dmemREN_EX_MEM;
  logic     dmemWEN_EX_MEM;
  logic     halt_EX_MEM;
  logic     branch_taken_EX_MEM;
  logic     memread_ID_EX;
  regbits_t Rt_ID_EX;
  regbits_t Rs_IF_ID;
  regbits_t Rt_IF_ID;

  logic     pc_enable;
  logic     enable_IF_ID;
  logic     enable_ID_EX;
  logic     enable_EX_MEM;
  logic     enable_MEM_WB;
  logic     flush_IF_ID;
  logic     flush_ID_EX;
  logic     flush_EX_MEM;
  logic     flush_MEM_WB;
  logic     halt;
  word_t    stall_count;

  modport slave (
    input  ihit, dhit, dmemREN_EX_MEM, dmemWEN_EX_MEM, halt_EX_MEM,
           branch_taken_EX_MEM, memread_ID_EX, Rt_ID_EX, Rs_IF_ID, Rt_IF_ID,
    output pc_enable, enable_IF_ID, enable_ID_EX, enable_EX_MEM, enable_MEM_WB,
           flush_IF_ID, flush_ID_EX, flush_EX_MEM, flush_MEM_WB, halt, stall_count
  );

  modport master (
    output ihit, dhit, dmemREN_EX_MEM, dmemWEN_EX_MEM, halt_EX_MEM,
           branch_taken_EX_MEM, memread_ID_EX, Rt_ID_EX, Rs_IF_ID, Rt_IF_ID,
    input  pc_enable, enable_IF_ID, enable_ID_EX, enable_EX_MEM, enable_MEM_WB,
           flush_IF_ID, flush_ID_EX, flush_EX_MEM, flush_MEM_WB, halt, stall_count
  );

endinterface

// File: rtl/pipeline_ctrl_hazard_detect.sv
// Load-use hazard compare: a load in ID/EX whose destination feeds the instruction in IF/ID.
module hazard_detect
  import cpu_types_pkg::*;
(
  input  logic     memread_i,
  input  regbits_t rt_id_ex_i,
  input  regbits_t rs_if_id_i,
  input  regbits_t rt_if_id_i,
  output logic     load_use_o
);

  logic dest_nonzero;
  logic src_match;

  // Register 0 is hard-wired, so a load targeting it never creates a dependency.
  assign dest_nonzero = (rt_id_ex_i != 5'd0);
  assign src_match    = (rt_id_ex_i == rs_if_id_i) | (rt_id_ex_i == rt_if_id_i);
  assign load_use_o   = memread_i & dest_nonzero & src_match;

endmodule

// File: rtl/pipeline_ctrl.sv
// Pipeline stall/flush controller: prioritised hazard resolution, halt drain sequence, stall counter.
module pipeline_ctrl
  import cpu_types_pkg::*;
  import data_path_muxs_pkg::*;
(
  input  logic           CLK,
  input  logic           nRST,
  pipeline_ctrl_if.slave pc_if
);

  pipe_ctrl_state_t state_q, state_d;
  word_t            stall_count_q, stall_count_d;
  ctrl_t            ctrl;
  logic             load_use;
  logic             dmem_wait;
  logic             stall_cycle;

  hazard_detect u_hazard_detect (
    .memread_i  (pc_if.memread_ID_EX),
    .rt_id_ex_i (pc_if.Rt_ID_EX),
    .rs_if_id_i (pc_if.Rs_IF_ID),
    .rt_if_id_i (pc_if.Rt_IF_ID),
    .load_use_o (load_use)
  );

  assign dmem_wait = (pc_if.dmemREN_EX_MEM | pc_if.dmemWEN_EX_MEM) & ~pc_if.dhit;

  // A pending halt outranks load-use and fetch stalls, and a taken branch hides a fetch miss.
  assign stall_cycle = dmem_wait |
                       (~pc_if.halt_EX_MEM & load_use) |
                       (~pc_if.halt_EX_MEM & ~pc_if.branch_taken_EX_MEM & ~pc_if.ihit);

  always_ff @(posedge CLK) begin
    if (!nRST) begin
      state_q       <= RUN;
      stall_count_q <= {WORD_W{1'b0}};
    end else begin
      state_q       <= state_d;
      stall_count_q <= stall_count_d;
    end
  end

  always_comb begin
    state_d       = state_q;
    stall_count_d = stall_count_q;
    case (state_q)
      RUN: begin
        if (stall_cycle) begin
          stall_count_d = stall_count_q + 32'd1;
        end else begin
          stall_count_d = stall_count_q;
        end
        if (!dmem_wait && pc_if.halt_EX_MEM) begin
          state_d = DRAIN;
        end else begin
          state_d = RUN;
        end
      end
      DRAIN:   state_d = HALTED;
      HALTED:  state_d = HALTED;
      default: state_d = RUN;
    endcase
  end

  always_comb begin
    ctrl = CTRL_RUN;
    case (state_q)
      RUN: begin
        if (dmem_wait) begin
          ctrl = CTRL_DMEM;
        end else if (pc_if.halt_EX_MEM) begin
          ctrl = CTRL_HALT;
        end else if (load_use) begin
          ctrl = CTRL_LU;
        end else if (pc_if.branch_taken_EX_MEM) begin
          ctrl = CTRL_BR;
        end else if (!pc_if.ihit) begin
          ctrl = CTRL_IMISS;
        end else begin
          ctrl = CTRL_RUN;
        end
      end
      DRAIN:   ctrl = CTRL_IDLE;
      HALTED:  ctrl = CTRL_IDLE;
      default: ctrl = CTRL_RUN;
    endcase
  end

  assign pc_if.pc_enable     = ctrl.pc_en;
  assign pc_if.enable_IF_ID  = ctrl.en_if_id;
  assign pc_if.enable_ID_EX  = ctrl.en_id_ex;
  assign pc_if.enable_EX_MEM = ctrl.en_ex_mem;
  assign pc_if.enable_MEM_WB = ctrl.en_mem_wb;
  assign pc_if.flush_IF_ID   = ctrl.fl_if_id;
  assign pc_if.flush_ID_EX   = ctrl.fl_id_ex;
  assign pc_if.flush_EX_MEM  = ctrl.fl_ex_mem;
  assign pc_if.flush_MEM_WB  = ctrl.fl_mem_wb;
  assign pc_if.halt          = (state_q == HALTED);
  assign pc_if.stall_count   = stall_count_q;

endmodule

// File: tb/tb_pipeline_ctrl.sv
// Self-checking bench for pipeline_ctrl: vector table, directed sequences, randomized model comparison.
module tb_pipeline_ctrl;
  import cpu_types_pkg::*;

  logic CLK;
  logic nRST;
  int   tests;
  int   fails;

  pipeline_ctrl_if pif();

  pipeline_ctrl u_dut (
    .CLK   (CLK),
    .nRST  (nRST),
    .pc_if (pif)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // Expected {pc, en IF/ID, ID/EX, EX/MEM, MEM/WB, fl IF/ID, ID/EX, EX/MEM, MEM/WB}
  localparam logic [8:0] O_RUN   = 9'b11111_0000;
  localparam logic [8:0] O_IDLE  = 9'b00000_0000;
  localparam logic [8:0] O_DMEM  = 9'b00001_0001;
  localparam logic [8:0] O_HALT  = 9'b01111_1110;
  localparam logic [8:0] O_LU    = 9'b00111_0100;
  localparam logic [8:0] O_BR    = 9'b11111_1110;
  localparam logic [8:0] O_IMISS = 9'b01111_1000;

  // ctl = {ihit, dhit, ren, wen, halt, branch, memread}; regs = {Rt_ID_EX, Rs_IF_ID, Rt_IF_ID}
  typedef struct {
    string       nm;
    logic [6:0]  ctl;
    logic [14:0] regs;
    logic [8:0]  exp;
    logic        stall;
  } vec_t;

  vec_t        vecs [15];
  logic [6:0]  cur_c;
  logic [14:0] cur_r;

  function automatic logic [8:0] outs();
    return {pif.pc_enable, pif.enable_IF_ID, pif.enable_ID_EX, pif.enable_EX_MEM,
            pif.enable_MEM_WB, pif.flush_IF_ID, pif.flush_ID_EX, pif.flush_EX_MEM,
            pif.flush_MEM_WB};
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s actual=%h required=%h", nm, act, exp);
    end
  endtask

  task automatic drive(input logic [6:0] c, input logic [14:0] r);
    cur_c                   = c;
    cur_r                   = r;
    pif.ihit                = c[6];
    pif.dhit                = c[5];
    pif.dmemREN_EX_MEM      = c[4];
    pif.dmemWEN_EX_MEM      = c[3];
    pif.halt_EX_MEM         = c[2];
    pif.branch_taken_EX_MEM = c[1];
    pif.memread_ID_EX       = c[0];
    pif.Rt_ID_EX            = r[14:10];
    pif.Rs_IF_ID            = r[9:5];
    pif.Rt_IF_ID            = r[4:0];
  endtask

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic do_reset();
    nRST = 1'b0;
    drive(7'b1000000, 15'd0);
    step();
    nRST = 1'b1;
  endtask

  // Reference: highest-priority applicable rule decides the stage controls.
  function automatic void model_eval(input int st, input logic [6:0] c, input logic [14:0] r,
                                     output logic [8:0] o, output logic stall,
                                     output logic to_drain);
    logic [4:0] rtx, rs, rt;
    logic       lu, wait_mem;
    rtx      = r[14:10];
    rs       = r[9:5];
    rt       = r[4:0];
    lu       = c[0] && (rtx != 5'd0) && (rtx == rs || rtx == rt);
    wait_mem = (c[4] || c[3]) && !c[5];
    stall    = 1'b0;
    to_drain = 1'b0;
    if (st != 0)        o = O_IDLE;
    else if (wait_mem)  begin o = O_DMEM;  stall = 1'b1; end
    else if (c[2])      begin o = O_HALT;  to_drain = 1'b1; end
    else if (lu)        begin o = O_LU;    stall = 1'b1; end
    else if (c[1])      o = O_BR;
    else if (!c[6])     begin o = O_IMISS; stall = 1'b1; end
    else                o = O_RUN;
  endfunction

  initial begin
    logic [31:0] cnt_before;
    logic [8:0]  m_o;
    logic        m_stall, m_drain, rst_now;
    int          m_st, halted_cycles;
    logic [31:0] m_cnt;

    tests = 0;
    fails = 0;
    nRST  = 1'b0;
    drive(7'b1000000, 15'd0);

    vecs[0]  = '{"idle",             7'b1000000, {5'd0, 5'd0, 5'd0}, O_RUN,   1'b0};
    vecs[1]  = '{"dmem_rd_wait",     7'b1010000, {5'd0, 5'd0, 5'd0}, O_DMEM,  1'b1};
    vecs[2]  = '{"dmem_wr_wait",     7'b1001000, {5'd0, 5'd0, 5'd0}, O_DMEM,  1'b1};
    vecs[3]  = '{"dmem_done",        7'b1110000, {5'd0, 5'd0, 5'd0}, O_RUN,   1'b0};
    vecs[4]  = '{"lu_rs",            7'b1000001, {5'd5, 5'd5, 5'd0}, O_LU,    1'b1};
    vecs[5]  = '{"lu_rt",            7'b1000001, {5'd7, 5'd1, 5'd7}, O_LU,    1'b1};
    vecs[6]  = '{"lu_r0",            7'b1000001, {5'd0, 5'd0, 5'd0}, O_RUN,   1'b0};
    vecs[7]  = '{"no_memread",       7'b1000000, {5'd5, 5'd5, 5'd5}, O_RUN,   1'b0};
    vecs[8]  = '{"branch_imiss",     7'b0000010, {5'd0, 5'd0, 5'd0}, O_BR,    1'b0};
    vecs[9]  = '{"imiss",            7'b0000000, {5'd0, 5'd0, 5'd0}, O_IMISS, 1'b1};
    vecs[10] = '{"dmem_over_branch", 7'b1010010, {5'd0, 5'd0, 5'd0}, O_DMEM,  1'b1};
    vecs[11] = '{"lu_over_branch",   7'b1000011, {5'd3, 5'd3, 5'd0}, O_LU,    1'b1};
    vecs[12] = '{"dmem_over_halt",   7'b1011100, {5'd0, 5'd0, 5'd0}, O_DMEM,  1'b1};
    vecs[13] = '{"lu_and_imiss",     7'b0000001, {5'd9, 5'd0, 5'd9}, O_LU,    1'b1};
    vecs[14] = '{"lu_no_match",      7'b1000001, {5'd5, 5'd6, 5'd7}, O_RUN,   1'b0};

    step();
    nRST = 1'b1;
    #1;
    chk("reset_outs", {55'd0, outs()}, {55'd0, O_RUN});
    chk("reset_halt", {63'd0, pif.halt}, 64'd0);
    chk("reset_count", {32'd0, pif.stall_count}, 64'd0);

    // Table: each vector from RUN, same-cycle outputs then counter increment.
    for (int i = 0; i < 15; i++) begin
      drive(vecs[i].ctl, vecs[i].regs);
      #1;
      cnt_before = pif.stall_count;
      chk({vecs[i].nm, "_outs"}, {55'd0, outs()}, {55'd0, vecs[i].exp});
      step();
      chk({vecs[i].nm, "_count"}, {32'd0, pif.stall_count},
          {32'd0, cnt_before + {31'd0, vecs[i].stall}});
      chk({vecs[i].nm, "_halt"}, {63'd0, pif.halt}, 64'd0);
    end

    // Three dmem wait cycles then completion.
    do_reset();
    for (int i = 0; i < 3; i++) begin
      drive(7'b1010000, 15'd0);
      #1;
      chk("dmem3_stall", {55'd0, outs()}, {55'd0, O_DMEM});
      step();
    end
    drive(7'b1110000, 15'd0);
    #1;
    chk("dmem3_release", {55'd0, outs()}, {55'd0, O_RUN});
    step();
    chk("dmem3_count", {32'd0, pif.stall_count}, 64'd3);

    // Halt with simultaneous fetch miss, drain, then sticky halted state.
    do_reset();
    drive(7'b0100100, 15'd0);
    #1;
    chk("halt_outs", {55'd0, outs()}, {55'd0, O_HALT});
    step();
    chk("halt_count", {32'd0, pif.stall_count}, 64'd0);
    drive(7'b0010001, {5'd4, 5'd4, 5'd4});
    #1;
    chk("drain_outs", {55'd0, outs()}, {55'd0, O_IDLE});
    chk("drain_halt", {63'd0, pif.halt}, 64'd0);
    step();
    for (int i = 0; i < 10; i++) begin
      drive(7'b0010000, 15'd0);
      #1;
      chk("halted_outs", {55'd0, outs()}, {55'd0, O_IDLE});
      chk("halted_halt", {63'd0, pif.halt}, 64'd1);
      step();
    end
    chk("halted_count", {32'd0, pif.stall_count}, 64'd0);

    // Reset while halted.
    nRST = 1'b0;
    drive(7'b1000000, 15'd0);
    step();
    nRST = 1'b1;
    #1;
    chk("rst_halted_outs", {55'd0, outs()}, {55'd0, O_RUN});
    chk("rst_halted_halt", {63'd0, pif.halt}, 64'd0);

    // Reset in the middle of a dmem wait.
    drive(7'b1010000, 15'd0);
    step();
    step();
    chk("pre_rst_count", {32'd0, pif.stall_count}, 64'd2);
    nRST = 1'b0;
    #1;
    chk("rst_cycle_outs", {55'd0, outs()}, {55'd0, O_DMEM});
    step();
    chk("rst_dmem_count", {32'd0, pif.stall_count}, 64'd0);
    nRST = 1'b1;
    drive(7'b1000000, 15'd0);
    #1;
    chk("rst_dmem_outs", {55'd0, outs()}, {55'd0, O_RUN});

    // Counter wrap from all-ones.
    force u_dut.stall_count_q = 32'hFFFF_FFFF;
    #1;
    chk("wrap_preload", {32'd0, pif.stall_count}, {32'd0, 32'hFFFF_FFFF});
    release u_dut.stall_count_q;
    drive(7'b0000000, 15'd0);
    step();
    chk("wrap_count", {32'd0, pif.stall_count}, 64'd0);

    // Randomized comparison against the reference model.
    do_reset();
    m_st          = 0;
    m_cnt         = 32'd0;
    halted_cycles = 0;
    for (int n = 0; n < 2000; n++) begin
      rst_now = ($urandom_range(0, 59) == 0) || (halted_cycles >= 3);
      nRST    = !rst_now;
      drive({($urandom_range(0, 3) != 0), $urandom_range(0, 1) == 1,
             ($urandom_range(0, 3) == 0), ($urandom_range(0, 5) == 0),
             ($urandom_range(0, 39) == 0), ($urandom_range(0, 5) == 0),
             ($urandom_range(0, 2) == 0)},
            {5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3))});
      #1;
      model_eval(m_st, cur_c, cur_r, m_o, m_stall, m_drain);
      chk("random", {22'd0, outs(), pif.halt, pif.stall_count},
          {22'd0, m_o, (m_st == 2), m_cnt});
      if (rst_now) begin
        m_st  = 0;
        m_cnt = 32'd0;
      end else if (m_st == 0) begin
        if (m_stall) m_cnt = m_cnt + 32'd1;
        if (m_drain) m_st = 1;
      end else if (m_st == 1) begin
        m_st = 2;
      end
      halted_cycles = (m_st == 2) ? halted_cycles + 1 : 0;
      step();
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
